// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared tile geometry defaults and array types for the assembler and transpose stage
package matrix_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NUM_MG     = 8;
  localparam int DEF_NUM_PE     = DEF_NUM_MG;

  // Element slot width; wider slots when a column carries several module groups
  function automatic int chunk_width(input int num_mg, input int num_pe, input int data_width);
    return (num_mg / num_pe) * data_width;
  endfunction

  localparam int DEF_CHUNK_WIDTH = chunk_width(DEF_NUM_MG, DEF_NUM_PE, DEF_DATA_WIDTH);

  typedef logic [DEF_CHUNK_WIDTH-1:0] chunk_t;
  typedef chunk_t row_t [0:DEF_NUM_PE-1];
  typedef chunk_t tile_t [0:DEF_NUM_MG-1][0:DEF_NUM_PE-1];

endpackage

// File: rtl/tile_bank.sv
// rtl/tile_bank.sv - one tile buffer bank with row write port, ctrl bit and full flag
module tile_bank
  import matrix_pkg::*;
#(
  parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH,
  parameter int NUM_MG      = DEF_NUM_MG,
  parameter int NUM_PE      = DEF_NUM_PE,
  parameter int ROW_W       = (NUM_MG > 1) ? $clog2(NUM_MG) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ROW_W-1:0]       wr_row,
  input  logic [CHUNK_WIDTH-1:0] wr_data [0:NUM_PE-1],
  input  logic                   ctrl_in,
  input  logic                   set_full,
  input  logic                   clr_full,
  output logic [CHUNK_WIDTH-1:0] data [0:NUM_MG-1][0:NUM_PE-1],
  output logic                   ctrl,
  output logic                   full
);

  // Row storage: one row written per accepted transfer, everything cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_MG; r++) begin
        for (int c = 0; c < NUM_PE; c++) begin
          data[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int c = 0; c < NUM_PE; c++) begin
        data[wr_row][c] <= wr_data[c];
      end
    end
  end

  // Transpose flag is captured only with the first row of the tile
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= 1'b0;
    end else if (wr_en && (wr_row == '0)) begin
      ctrl <= ctrl_in;
    end
  end

  // Full flag: set by the last row write, cleared when the tile is taken downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/matrix_tile_assembler.sv
// rtl/matrix_tile_assembler.sv - ping-pong assembler collecting rows into tiles for the transpose stage
module matrix_tile_assembler
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_MG     = DEF_NUM_MG,
  parameter int NUM_PE     = NUM_MG
) (
  input  logic clk,
  input  logic rst,
  input  logic [chunk_width(NUM_MG, NUM_PE, DATA_WIDTH)-1:0] row_in [0:NUM_PE-1],
  input  logic row_val,
  output logic row_rdy,
  input  logic transpose_in,
  output logic [chunk_width(NUM_MG, NUM_PE, DATA_WIDTH)-1:0] tile_out [0:NUM_MG-1][0:NUM_PE-1],
  output logic tile_ctrl,
  output logic tile_val,
  input  logic tile_rdy
);

  localparam int CHUNK_WIDTH = chunk_width(NUM_MG, NUM_PE, DATA_WIDTH);
  localparam int ROW_W       = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_MG - 1);

  logic [ROW_W-1:0] row_cnt;
  logic             fill_ptr;
  logic             out_ptr;
  logic [1:0]       full;
  logic [1:0]       ctrl;
  logic [1:0]       bank_wr;
  logic [1:0]       bank_set;
  logic [1:0]       bank_clr;
  logic             row_xfer;
  logic             tile_xfer;
  logic             last_row;

  logic [CHUNK_WIDTH-1:0] bank0_data [0:NUM_MG-1][0:NUM_PE-1];
  logic [CHUNK_WIDTH-1:0] bank1_data [0:NUM_MG-1][0:NUM_PE-1];

  // Handshakes come purely from registered flags, so no ready/valid path crosses the block
  assign row_rdy   = ~full[fill_ptr];
  assign tile_val  = full[out_ptr];
  assign row_xfer  = row_val & row_rdy;
  assign tile_xfer = tile_val & tile_rdy;
  assign last_row  = row_xfer && (row_cnt == LAST_ROW);

  // Steer the row write/full-set to the fill bank and the full-clear to the output bank
  always_comb begin
    bank_wr  = 2'b00;
    bank_set = 2'b00;
    bank_clr = 2'b00;
    bank_wr[fill_ptr]  = row_xfer;
    bank_set[fill_ptr] = last_row;
    bank_clr[out_ptr]  = tile_xfer;
  end

  // Row counter and bank pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt  <= '0;
      fill_ptr <= 1'b0;
      out_ptr  <= 1'b0;
    end else begin
      if (row_xfer) begin
        row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
      end
      if (last_row) begin
        fill_ptr <= ~fill_ptr;
      end
      if (tile_xfer) begin
        out_ptr <= ~out_ptr;
      end
    end
  end

  tile_bank #(
    .CHUNK_WIDTH (CHUNK_WIDTH),
    .NUM_MG      (NUM_MG),
    .NUM_PE      (NUM_PE),
    .ROW_W       (ROW_W)
  ) u_bank0 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bank_wr[0]),
    .wr_row   (row_cnt),
    .wr_data  (row_in),
    .ctrl_in  (transpose_in),
    .set_full (bank_set[0]),
    .clr_full (bank_clr[0]),
    .data     (bank0_data),
    .ctrl     (ctrl[0]),
    .full     (full[0])
  );

  tile_bank #(
    .CHUNK_WIDTH (CHUNK_WIDTH),
    .NUM_MG      (NUM_MG),
    .NUM_PE      (NUM_PE),
    .ROW_W       (ROW_W)
  ) u_bank1 (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bank_wr[1]),
    .wr_row   (row_cnt),
    .wr_data  (row_in),
    .ctrl_in  (transpose_in),
    .set_full (bank_set[1]),
    .clr_full (bank_clr[1]),
    .data     (bank1_data),
    .ctrl     (ctrl[1]),
    .full     (full[1])
  );

  // Output mux always presents the bank at out_ptr
  always_comb begin
    tile_out  = out_ptr ? bank1_data : bank0_data;
    tile_ctrl = ctrl[out_ptr];
  end

endmodule

// File: tb/tb_matrix_tile_assembler.sv
// tb/tb_matrix_tile_assembler.sv - scoreboard bench for matrix_tile_assembler
module tb_matrix_tile_assembler;

  localparam int MG = 8;
  localparam int PE = 8;
  localparam int DW = 64;
  localparam int TW = MG * PE * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] row_in [0:PE-1];
  logic          row_val;
  logic          row_rdy;
  logic          transpose_in;
  logic [DW-1:0] tile_out [0:MG-1][0:PE-1];
  logic          tile_ctrl;
  logic          tile_val;
  logic          tile_rdy;

  int n_cmp = 0;
  int n_err = 0;

  logic [TW-1:0] tile_q [$];
  bit            ctrl_q [$];
  logic [TW-1:0] part;
  bit            part_ctrl;
  int            m_row;
  int            tile_seq;
  int            pulses;

  always #5 clk = ~clk;

  matrix_tile_assembler #(
    .DATA_WIDTH (DW),
    .NUM_MG     (MG),
    .NUM_PE     (PE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .row_in       (row_in),
    .row_val      (row_val),
    .row_rdy      (row_rdy),
    .transpose_in (transpose_in),
    .tile_out     (tile_out),
    .tile_ctrl    (tile_ctrl),
    .tile_val     (tile_val),
    .tile_rdy     (tile_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] elem(input int seq, input int r, input int c);
    return DW'(seq * 4096 + 16 * r + c);
  endfunction

  task automatic model_reset();
    tile_q.delete();
    ctrl_q.delete();
    part      = '0;
    part_ctrl = 1'b0;
    m_row     = 0;
    tile_seq++;
  endtask

  // Compare the settled outputs, drive one cycle of inputs, advance the model, clock
  task automatic step(input bit r_st, input bit rv, input bit tin, input bit trdy);
    bit exp_rdy;
    bit exp_val;
    bit r_x;
    bit t_x;
    logic [TW-1:0] front;
    exp_rdy = (tile_q.size() < 2);
    exp_val = (tile_q.size() > 0);
    chk("row_rdy", row_rdy, exp_rdy);
    chk("tile_val", tile_val, exp_val);
    if (exp_val) begin
      front = tile_q[0];
      chk("tile_ctrl", tile_ctrl, ctrl_q[0]);
      for (int r = 0; r < MG; r++)
        for (int c = 0; c < PE; c++)
          chk($sformatf("tile_out[%0d][%0d]", r, c), tile_out[r][c], front[(r*PE+c)*DW +: DW]);
    end
    rst          = r_st;
    row_val      = rv;
    transpose_in = tin;
    tile_rdy     = trdy;
    for (int c = 0; c < PE; c++)
      row_in[c] = rv ? elem(tile_seq, m_row, c) : {$urandom(), $urandom()};
    if (r_st) begin
      model_reset();
    end else begin
      t_x = exp_val && trdy;
      r_x = rv && exp_rdy;
      if (t_x) begin
        void'(tile_q.pop_front());
        void'(ctrl_q.pop_front());
      end
      if (r_x) begin
        for (int c = 0; c < PE; c++)
          part[(m_row*PE+c)*DW +: DW] = elem(tile_seq, m_row, c);
        if (m_row == 0) part_ctrl = tin;
        if (m_row == MG - 1) begin
          tile_q.push_back(part);
          ctrl_q.push_back(part_ctrl);
          tile_seq++;
          m_row = 0;
        end else begin
          m_row++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (tile_q.size() > 0 && n < 20) begin
      step(0, 0, 0, 1);
      n++;
    end
    chk("drain_left", 64'(tile_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    row_val = 1'b0;
    transpose_in = 1'b0;
    tile_rdy = 1'b0;
    for (int c = 0; c < PE; c++) row_in[c] = '0;
    tile_seq = 0;
    model_reset();
    tile_seq = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst_tile_val", tile_val, 1'b0);
    chk("rst_tile_ctrl", tile_ctrl, 1'b0);
    chk("rst_row_rdy", row_rdy, 1'b1);
    for (int r = 0; r < MG; r++)
      for (int c = 0; c < PE; c++)
        chk($sformatf("rst_tile_out[%0d][%0d]", r, c), tile_out[r][c], 64'd0);

    // streaming single tile
    for (int i = 0; i < MG; i++) step(0, 1, (i == 0), 1);
    chk("stream_val", tile_val, 1'b1);
    chk("stream_3_5", tile_out[3][5], 64'd53);
    chk("stream_ctrl", tile_ctrl, 1'b1);
    step(0, 0, 0, 1);
    chk("stream_one_cycle", tile_val, 1'b0);

    // back-to-back tiles; transpose_in off row 0 must be ignored
    for (int i = 0; i < 2 * MG; i++)
      step(0, 1, (i == 8) ? 1'b1 : ((i == 0) ? 1'b0 : 1'($urandom_range(0, 1))), 1);
    drain();

    // backpressure: 24 rows offered, only 16 fit
    for (int i = 0; i < 3 * MG; i++) step(0, 1, 1'($urandom_range(0, 1)), 0);
    chk("bp_rdy_low", row_rdy, 1'b0);
    step(0, 0, 0, 1);
    chk("bp_rdy_back", row_rdy, 1'b1);
    drain();

    // final row of bank 1 coinciding with the tile 0 transfer
    for (int i = 0; i < 2 * MG - 1; i++) step(0, 1, 1'(i == 0), 0);
    step(0, 1, 0, 1);
    chk("simul_val", tile_val, 1'b1);
    drain();

    // reset with one full and one partial tile pending, asserted with live handshakes
    for (int i = 0; i < MG + 5; i++) step(0, 1, 1, 0);
    step(1, 1, 1, 1);
    pulses = 0;
    for (int i = 0; i < MG + 4; i++) begin
      step(0, (i < MG), 0, 1);
      if (tile_val === 1'b1) pulses++;
    end
    chk("rst_pulses", 64'(pulses), 64'd1);

    // gapped input with garbage on idle cycles
    for (int i = 0; i < 2 * MG; i++) step(0, (i % 2 == 0), 1'($urandom_range(0, 1)), 1);
    step(0, 0, 0, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
